// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready handshake blocks (master_3 / slave_3).
//   DATA_W  : default channel word width
//   state_t : transmitter state encoding (IDLE, SEND, DONE)
package hs_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with no fall-through: a word written at one edge becomes
// visible on head at the next edge.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push       : write wr_data when not full (dropped silently when full)
//   pop        : advance the read pointer when not empty
//   full/empty : occupancy flags, both taken from the registered count
//   fill       : registered occupancy, 0..DEPTH
//   head       : word at the read pointer
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [DATA_W-1:0]        head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign fill  = count_q;
    assign head  = mem[rd_ptr_q];

    // full is the pre-pop flag, so a write to a full FIFO is lost even if a
    // pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end
endmodule

// File: rtl/master_3.sv
// Burst transmitter for a valid/ready channel. Words are queued into an
// internal FIFO; a start pulse in IDLE sends burst_len beats, obeying source
// rules (valid never depends on ready, data/last held until accepted).
//   clk, rst_n           : clock, asynchronous active-low reset
//   wr_en, wr_data       : FIFO write side; full, fill report occupancy
//   start, burst_len     : burst launch (burst_len==0 ignored)
//   busy, done           : not-IDLE flag, one-cycle completion pulse
//   data, valid, ready   : channel; last marks the final beat
module master_3 #(
    parameter int DATA_W = hs_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fill,
    input  logic                     start,
    input  logic [LEN_W-1:0]         burst_len,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        data,
    output logic                     valid,
    input  logic                     ready,
    output logic                     last
);
    import hs_pkg::*;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  to_load_q, to_load_d;   // beats not yet loaded
    logic [LEN_W-1:0]  to_send_q, to_send_d;   // beats not yet accepted
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic              fifo_pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              handshake;
    logic              load;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (fifo_pop),
        .full    (full),
        .empty   (fifo_empty),
        .fill    (fill),
        .head    (fifo_head)
    );

    assign handshake = valid_q && ready;

    always_comb begin
        state_d   = state_q;
        to_load_d = to_load_q;
        to_send_d = to_send_q;
        data_d    = data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (burst_len != '0)) begin
                    to_load_d = burst_len;
                    to_send_d = burst_len;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // The output register may be refilled when empty or when its
                // current word is being accepted this edge (no bubble).
                load = (to_load_q != '0) && !fifo_empty && (!valid_q || ready);
                if (load) begin
                    fifo_pop  = 1'b1;
                    data_d    = fifo_head;
                    valid_d   = 1'b1;
                    to_load_d = to_load_q - LEN_W'(1);
                end else if (handshake) begin
                    valid_d = 1'b0;
                end
                if (handshake) begin
                    to_send_d = to_send_q - LEN_W'(1);
                    if (to_send_q == LEN_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            to_load_q <= '0;
            to_send_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_load_q <= to_load_d;
            to_send_q <= to_send_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign last  = valid_q && (to_send_q == LEN_W'(1));
endmodule

// File: tb/tb_master_3.sv
module tb_master_3;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              full;
    logic [3:0]        fill;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready = 1'b0;
    logic              last;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    // Beats accepted by the receiver, as seen on the channel
    logic [DATA_W-1:0] beat_log[$];
    bit                last_log[$];

    // Reference model state
    logic [DATA_W-1:0] m_fifo[$];
    bit                m_valid;
    logic [DATA_W-1:0] m_data;
    int                m_to_load;
    int                m_to_send;
    int                m_phase;    // 0 idle, 1 sending, 2 done pulse

    master_3 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .fill      (fill),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .last      (last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_valid   = 1'b0;
        m_data    = '0;
        m_to_load = 0;
        m_to_send = 0;
        m_phase   = 0;
    endtask

    // One clock edge of the specified behaviour, using inputs as they stand
    task automatic model_step();
        bit                push_ok;
        bit                hs;
        logic [DATA_W-1:0] w;
        push_ok = wr_en && (m_fifo.size() < DEPTH);
        hs      = m_valid && ready;
        w       = wr_data;
        case (m_phase)
            0: begin
                if (start && burst_len != 0) begin
                    m_to_load = int'(burst_len);
                    m_to_send = int'(burst_len);
                    m_phase   = 1;
                end
            end
            1: begin
                if (m_to_load > 0 && m_fifo.size() > 0 && (!m_valid || ready)) begin
                    m_data    = m_fifo.pop_front();
                    m_valid   = 1'b1;
                    m_to_load = m_to_load - 1;
                end else if (hs) begin
                    m_valid = 1'b0;
                end
                if (hs) begin
                    m_to_send = m_to_send - 1;
                    if (m_to_send == 0) m_phase = 2;
                end
            end
            default: begin
                m_valid = 1'b0;
                m_phase = 0;
            end
        endcase
        if (push_ok) m_fifo.push_back(w);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: outputs against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("valid", 32'(valid), 32'(m_valid));
                check("data", data, m_data);
                check("last", 32'(last), 32'(m_valid && m_to_send == 1));
                check("done", 32'(done), 32'(m_phase == 2));
                check("busy", 32'(busy), 32'(m_phase != 0));
                check("fill", 32'(fill), 32'(m_fifo.size()));
                check("full", 32'(full), 32'(m_fifo.size() == DEPTH));
                if (done) done_cnt++;
                if (valid && ready) begin
                    beat_log.push_back(data);
                    last_log.push_back(last);
                    $display("[TB] beat data=%0h last=%0b", data, last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic launch(input int len);
        start     = 1'b1;
        burst_len = LEN_W'(len);
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
        end
    endtask

    task automatic clear_logs();
        beat_log.delete();
        last_log.delete();
        done_cnt = 0;
    endtask

    // Literal expectation: n consecutive words from base, last only on the final one
    task automatic check_log(input string tag, input int n, input logic [31:0] base);
        check({tag, "_count"}, 32'(beat_log.size()), 32'(n));
        for (int i = 0; i < n && i < beat_log.size(); i++) begin
            check({tag, "_word"}, beat_log[i], base + 32'(i));
            check({tag, "_lastflag"}, 32'(last_log[i]), 32'(i == n - 1));
        end
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic burst, ready held high
        clear_logs();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        launch(4);
        check("t1_lat_k", 32'(valid), 32'd0);
        tick();
        check("t1_lat_k1_valid", 32'(valid), 32'd1);
        check("t1_lat_k1_data", data, 32'hA0);
        wait_idle();
        check_log("t1", 4, 32'hA0);
        check("t1_fill", 32'(fill), 32'd0);

        // Stall on the second beat for three cycles
        clear_logs();
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        launch(4);
        tick();
        tick();
        ready = 1'b0;
        repeat (3) tick();
        check("t2_hold_data", data, 32'hA1);
        check("t2_hold_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        wait_idle();
        check_log("t2", 4, 32'hA0);

        // Underflow mid-burst
        clear_logs();
        push(32'hB0);
        launch(3);
        repeat (4) tick();
        check("t3_gap_valid", 32'(valid), 32'd0);
        check("t3_gap_busy", 32'(busy), 32'd1);
        push(32'hB1);
        push(32'hB2);
        wait_idle();
        check_log("t3", 3, 32'hB0);

        // Full FIFO, write while full and popping is dropped
        clear_logs();
        for (int i = 0; i < 8; i++) push(32'hC0 + 32'(i));
        check("t4_full", 32'(full), 32'd1);
        check("t4_fill8", 32'(fill), 32'd8);
        launch(8);
        wr_en   = 1'b1;
        wr_data = 32'hFF;
        tick();
        wr_en   = 1'b0;
        check("t4_fill_after_drop", 32'(fill), 32'd7);
        wait_idle();
        check_log("t4", 8, 32'hC0);
        check("t4_fill_end", 32'(fill), 32'd0);

        // Zero-length start and start while busy are ignored
        clear_logs();
        launch(0);
        check("t5_len0_busy", 32'(busy), 32'd0);
        push(32'hD0);
        push(32'hD1);
        ready = 1'b0;
        launch(2);
        tick();
        tick();
        launch(5);
        check("t5_busy_mid", 32'(busy), 32'd1);
        ready = 1'b1;
        wait_idle();
        check_log("t5", 2, 32'hD0);
        tick();
        check("t5_no_relaunch", 32'(busy), 32'd0);

        // Reset during beat 2
        clear_logs();
        for (int i = 0; i < 4; i++) push(32'hE0 + 32'(i));
        launch(4);
        tick();
        tick();
        check("t6_pre_fill", 32'(fill), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_fill", 32'(fill), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        push(32'hF0);
        launch(1);
        wait_idle();
        check_log("t6", 1, 32'hF0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/master_3.md
# master_3

Transmitter end of the valid/ready handshake used by `slave_3`. Upstream logic pushes words into an internal FIFO. A `start` pulse then launches a burst of `burst_len` beats onto the `data`/`valid`/`ready` channel. The block follows AXI source rules: `valid` never waits on `ready`, and `data` is held stable until the handshake completes. It sits between the producer and any `slave_3`-style receiver.

## Interface
- `DATA_W`, 32, channel and FIFO word width
- `DEPTH`, 8, FIFO depth in words; power of two, ≥ 2
- `LEN_W`, 8, width of the burst-length field
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `wr_en` in 1: push `wr_data` into FIFO
- `wr_data` in DATA_W: word to push
- `full` out 1: FIFO holds DEPTH words
- `fill` out $clog2(DEPTH)+1: FIFO occupancy
- `start` in 1: launch burst, sampled only in IDLE
- `burst_len` in LEN_W: beats in burst; 0 means `start` is ignored
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse after final handshake
- `data` out DATA_W: channel payload
- `valid` out 1: payload valid
- `ready` in 1: receiver accepts
- `last` out 1: current beat is final beat of burst

## Operation
- Reset values (async on `rst_n`=0): `valid`=0, `data`=0, `last`=0, `done`=0, `busy`=0, `full`=0, `fill`=0, FIFO empty, state IDLE, counters 0.
- Handshake: a beat transfers at a rising edge with `valid`&&`ready`=1. While `valid`=1 and `ready`=0, `data` and `last` are frozen. `valid` drops only after a handshake.
- FIFO:
  - A push happens when `wr_en` && !`full`. `full` is evaluated before any same-cycle pop. `wr_en` while full is dropped silently, with no state change.
  - A pop happens when the load condition holds. Pop and push in the same cycle are both performed.
  - No fall-through: a word pushed at edge j is poppable at edge j+1.
- Counters (LEN_W bits each):
  - `to_load`: beats not yet moved into the output register.
  - `to_send`: beats not yet handshaked.
- States:
  - IDLE: on `start` && `burst_len`≠0, latch `to_load`=`to_send`=`burst_len`, go to SEND. Otherwise stay.
  - SEND:
    - Load condition: `to_load`≠0 && FIFO non-empty && (!`valid` || `ready`).
    - On load: `data` ← FIFO head, `valid` ← 1, `to_load` decrements.
    - On a handshake with no load: `valid` ← 0.
    - Each handshake decrements `to_send`. On the handshake with `to_send`=1, go to DONE.
  - DONE: `done`=1 for this single cycle, `valid`=0, then go to IDLE.
- `last` = `valid` && (`to_send`==1).
- Underflow mid-burst: the FIFO empties and `valid` falls after the pending handshake. The burst resumes when the FIFO refills. The burst is never aborted.
- `start` while busy is ignored. `burst_len` is sampled only at acceptance.
- `ready` high while `valid`=0 has no effect.
- `rst_n` low mid-burst: everything returns to reset values immediately and FIFO contents are discarded.

## Timing
- `start` accepted at edge k with FIFO non-empty: `valid`=1 after edge k+1.
- With `ready` held high and the FIFO non-empty: one beat per cycle, with no bubbles between beats.
- Final handshake at edge m: `done`=1 during cycle m..m+1, and `busy`=0 after edge m+1. The earliest next `start` is accepted at edge m+2.
- `fill` and `full` update at the edge after the push or pop.

## Structure
- Shared package `hs_pkg`: state enum (IDLE, SEND, DONE) and default DATA_W. `slave_3` also uses DATA_W from this package.
- Sub-module `sync_fifo`: parameters DATA_W and DEPTH; ports push, pop, `full`, `empty`, `fill`, head data; async active-low reset.
- Top level: FSM, two counters, and the output register.

## Test plan
- Reset, push 0xA0..0xA3, `start` with `burst_len`=4, `ready`=1 → beats A0,A1,A2,A3 on 4 consecutive edges. `last` is high with A3. `done` pulses once and `fill`=0.
- Same burst with `ready` low for 3 cycles on the second beat → `data`=0xA1 and `valid`=1 are held unchanged until `ready` rises. No beat is lost or duplicated.
- `burst_len`=3 with only 1 word queued, then push 2 more 5 cycles later → `valid` falls after beat 1 and resumes after the pushes. `last` is high on beat 3.
- Fill to DEPTH=8, then push 0xFF while full and popping → 0xFF is dropped and the output sequence contains only the original 8 words.
- `start` pulsed mid-burst, plus `burst_len`=0 in IDLE → both are ignored and `busy` stays unchanged.
- `rst_n` pulsed low during beat 2 of 4 → `valid`=0 and `fill`=0 immediately. A new `start` after release with a fresh push sends the new data.
